// File: rtl/aes_encipher_round_engine.sv
// Iterative AES encipher datapath (AES-128/192/256) with SubBytes time-multiplexed
// over SBOX_LANES 32-bit words per cycle against a shared external S-box array.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready=1, new_block holds last result, waits for next
//   INIT  | initial AddRoundKey with key index 0 on the sampled block
//   SBOX  | substitute SBOX_LANES state words per cycle through the S-box
//   MAIN  | ShiftRows, MixColumns (skipped in final round), AddRoundKey
module aes_encipher_round_engine #(
    parameter int SBOX_LANES = 1,
    parameter bit KEY256_EN  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      next,
    input  logic [1:0]                keylen,
    input  logic [127:0]              round_key,
    input  logic [127:0]              block,
    input  logic [32*SBOX_LANES-1:0]  new_sbox,
    output logic [3:0]                round,
    output logic [32*SBOX_LANES-1:0]  sbox,
    output logic [127:0]              new_block,
    output logic                      ready
);

    localparam int         S        = 4 / SBOX_LANES;
    localparam logic [1:0] CTR_LAST = 2'(S - 1);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   nr_q, nr_d, nr_sel;
    logic [1:0]   ctr_q, ctr_d;
    logic [127:0] block_q, block_d;
    logic [31:0]  word_q [4];
    logic [31:0]  sub_w  [4];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Row r of column c takes the byte of row r from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [1:0] lane_idx(input logic [1:0] ctr, input int lane);
        return 2'(int'(ctr) * SBOX_LANES + lane);
    endfunction

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            word_q[j] = block_q[127-32*j -: 32];
        end
    end

    always_comb begin
        nr_sel = 4'd10;
        if (KEY256_EN) begin
            case (keylen)
                2'b01:   nr_sel = 4'd12;
                2'b10:   nr_sel = 4'd14;
                default: nr_sel = 4'd10;
            endcase
        end
    end

    // Kept apart from the next-state logic: sbox depends only on registers,
    // so the external S-box path never closes a combinational loop.
    always_comb begin
        sbox = '0;
        if (state_q == SBOX) begin
            for (int i = 0; i < SBOX_LANES; i++) begin
                sbox[32*i +: 32] = word_q[lane_idx(ctr_q, i)];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        ctr_d   = ctr_q;
        block_d = block_q;
        sub_w   = word_q;
        case (state_q)
            IDLE: begin
                if (next) begin
                    nr_d    = nr_sel;
                    round_d = 4'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                block_d = block ^ round_key;
                round_d = 4'd1;
                ctr_d   = 2'd0;
                state_d = SBOX;
            end
            SBOX: begin
                for (int i = 0; i < SBOX_LANES; i++) begin
                    sub_w[lane_idx(ctr_q, i)] = new_sbox[32*i +: 32];
                end
                block_d = {sub_w[0], sub_w[1], sub_w[2], sub_w[3]};
                if (ctr_q == CTR_LAST) begin
                    ctr_d   = 2'd0;
                    state_d = MAIN;
                end else begin
                    ctr_d = ctr_q + 2'd1;
                end
            end
            MAIN: begin
                ctr_d = 2'd0;
                if (round_q < nr_q) begin
                    block_d = mix_columns(shift_rows(block_q)) ^ round_key;
                    round_d = round_q + 4'd1;
                    state_d = SBOX;
                end else begin
                    block_d = shift_rows(block_q) ^ round_key;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            nr_q    <= 4'd10;
            ctr_q   <= 2'd0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            ctr_q   <= ctr_d;
            block_q <= block_d;
        end
    end

    assign round     = round_q;
    assign new_block = block_q;
    assign ready     = (state_q == IDLE);

endmodule

// File: tb/tb_aes_encipher_round_engine.sv
// Directed bench for aes_encipher_round_engine: three lane widths, FIPS-197 vectors,
// bench-side key memory and S-box, scoreboard of expected ciphertext and latency.
module tb_aes_encipher_round_engine;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam int           NONE   = 1000;

    typedef struct {
        int           inst;
        logic [127:0] ct;
        int           lat;
        int           nr;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   nxt;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [127:0] rk   [16];
    logic [127:0] rkey [3];
    logic [3:0]   rnd  [3];
    logic [127:0] nb   [3];
    logic [2:0]   rdy;
    logic [127:0] sb_l4, ns_l4;
    logic [63:0]  sb_l2, ns_l2;
    logic [31:0]  sb_l1, ns_l1;
    exp_t         sbq [$];
    int           errors;
    int           checks;

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box computed from the GF(2^8) inverse (x^254) and the affine map.
    function automatic logic [7:0] sb_f(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_f(w[31:24]), sb_f(w[23:16]), sb_f(w[15:8]), sb_f(w[7:0])};
    endfunction

    function automatic int s_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    assign ns_l1 = sub_word(sb_l1);
    assign ns_l2 = {sub_word(sb_l2[63:32]), sub_word(sb_l2[31:0])};
    assign ns_l4 = {sub_word(sb_l4[127:96]), sub_word(sb_l4[95:64]),
                    sub_word(sb_l4[63:32]), sub_word(sb_l4[31:0])};
    assign rkey[0] = rk[rnd[0]];
    assign rkey[1] = rk[rnd[1]];
    assign rkey[2] = rk[rnd[2]];

    aes_encipher_round_engine #(.SBOX_LANES(4), .KEY256_EN(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .next(nxt[0]), .keylen(keylen),
        .round_key(rkey[0]), .block(block), .new_sbox(ns_l4),
        .round(rnd[0]), .sbox(sb_l4), .new_block(nb[0]), .ready(rdy[0]));

    aes_encipher_round_engine #(.SBOX_LANES(2), .KEY256_EN(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .next(nxt[1]), .keylen(keylen),
        .round_key(rkey[1]), .block(block), .new_sbox(ns_l2),
        .round(rnd[1]), .sbox(sb_l2), .new_block(nb[1]), .ready(rdy[1]));

    aes_encipher_round_engine #(.SBOX_LANES(1), .KEY256_EN(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .next(nxt[2]), .keylen(keylen),
        .round_key(rkey[2]), .block(block), .new_sbox(ns_l1),
        .round(rnd[2]), .sbox(sb_l1), .new_block(nb[2]), .ready(rdy[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Expectations are queued as the start is driven; n_ops=2 leaves next held high.
    task automatic start(input int k, input logic [1:0] kl, input logic [255:0] key,
                         input int nk, input int nr, input logic [127:0] ct, input int n_ops);
        exp_t e;
        expand(key, nk, nr);
        keylen = kl;
        block  = PT;
        for (int n = 0; n < n_ops; n++) begin
            e.inst = k;
            e.ct   = ct;
            e.lat  = 1 + nr * (s_of(k) + 1);
            e.nr   = nr;
            sbq.push_back(e);
        end
        nxt[k] = 1'b1;
        @(negedge clk);
        if (n_ops == 1) nxt[k] = 1'b0;
    endtask

    task automatic finish_op(input int k, input int poke);
        int         lat;
        bit         seq_ok;
        logic [3:0] prev;
        exp_t       e;
        lat    = 0;
        seq_ok = (rnd[k] == 4'd0);
        prev   = rnd[k];
        while (rdy[k] == 1'b0 && lat < 200) begin
            if (rnd[k] != prev && rnd[k] != prev + 4'd1) seq_ok = 1'b0;
            prev = rnd[k];
            if (lat == poke) begin
                nxt[k] = 1'b1;
                keylen = ~keylen;
                block  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (lat == poke + 1) nxt[k] = 1'b0;
            lat++;
            @(negedge clk);
        end
        chk("scoreboard_nonempty", 128'(sbq.size() != 0), 128'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("inst", 128'(k), 128'(e.inst));
            chk("ciphertext", nb[k], e.ct);
            chk("latency", 128'(lat), 128'(e.lat));
            chk("final_round", 128'(rnd[k]), 128'(e.nr));
            chk("round_sequence", 128'(seq_ok), 128'd1);
        end
        block = PT;
    endtask

    initial begin
        int cnt;
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        nxt     = '0;
        keylen  = 2'b00;
        block   = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 128'(rdy[k]), 128'd1);
            chk("rst_round", 128'(rnd[k]), 128'd0);
            chk("rst_block", nb[k], 128'd0);
        end
        chk("rst_sbox", 128'(sb_l1), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // AES-128, one lane
        start(2, 2'b00, K128, 4, 10, CT128, 1);
        finish_op(2, NONE);
        chk("idle_sbox", 128'(sb_l1), 128'd0);
        // AES-192, two lanes
        start(1, 2'b01, K192, 6, 12, CT192, 1);
        finish_op(1, NONE);
        // AES-256, four lanes
        start(0, 2'b10, K256, 8, 14, CT256, 1);
        finish_op(0, NONE);
        // keylen=11 behaves as AES-128
        start(2, 2'b11, K128, 4, 10, CT128, 1);
        finish_op(2, NONE);

        // next, keylen and block disturbed while busy
        start(1, 2'b01, K192, 6, 12, CT192, 1);
        finish_op(1, 6);
        @(negedge clk);
        chk("no_restart", 128'(rdy[1]), 128'd1);

        // next held high: back-to-back operations
        start(2, 2'b00, K128, 4, 10, CT128, 2);
        finish_op(2, NONE);
        @(negedge clk);
        chk("b2b_restart", 128'(rdy[2]), 128'd0);
        nxt[2] = 1'b0;
        finish_op(2, NONE);

        // asynchronous reset at round 5
        start(2, 2'b00, K128, 4, 10, CT128, 1);
        cnt = 0;
        while (rnd[2] != 4'd5 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("reach_round5", 128'(rnd[2]), 128'd5);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", 128'(rdy[2]), 128'd1);
        chk("abort_round", 128'(rnd[2]), 128'd0);
        chk("abort_block", nb[2], 128'd0);
        if (sbq.size() != 0) sbq.delete(0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start(2, 2'b00, K128, 4, 10, CT128, 1);
        finish_op(2, NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
